// File: rtl/coin_pkg.sv
// Shared definitions for the coin-tube scan reader and the display self-test.
package coin_pkg;

  localparam int LEVEL_W   = 9;
  localparam int MAX_LEVEL = 8;

  localparam logic [3:0] SEL_C50  = 4'b1000;
  localparam logic [3:0] SEL_C20  = 4'b0100;
  localparam logic [3:0] SEL_C10  = 4'b0010;
  localparam logic [3:0] SEL_C5   = 4'b0001;
  localparam logic [3:0] SEL_IDLE = 4'b0000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_COMMIT
  } scanState_t;

  // Step the one-hot selector C50 -> C20 -> C10 -> C5 -> C50
  function automatic logic [3:0] nextSel(input logic [3:0] sel);
    return {sel[0], sel[3:1]};
  endfunction

endpackage

// File: rtl/therm_enc.sv
// Thermometer decoder: turns a 9-bit level code into a count 0..8 plus a legality flag.
module therm_enc
  import coin_pkg::*;
(
  input  logic [LEVEL_W-1:0] i_f,
  output logic [3:0]         o_n,
  output logic               o_ok
);

  // Only the contiguous low-filled codes (1<<n)-1 for n=0..8 are legal; all ones is not
  always_comb begin
    o_n  = 4'd0;
    o_ok = 1'b0;
    for (int k = 0; k <= MAX_LEVEL; k++) begin
      if (i_f == LEVEL_W'((1 << k) - 1)) begin
        o_n  = 4'(k);
        o_ok = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tube_scan_enc.sv
// Coin-tube level scanner: walks the tube selector, debounces each thermometer reading
// and keeps the last accepted count per denomination.
module tube_scan_enc
  import coin_pkg::*;
#(
  parameter int DWELL     = 4,
  parameter int STABLE    = 2,
  parameter int MAX_TRIES = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_en,
  input  logic [LEVEL_W-1:0] i_f,
  output logic [3:0]         o_s,
  output logic [LEVEL_W-1:0] o_c50,
  output logic [LEVEL_W-1:0] o_c20,
  output logic [LEVEL_W-1:0] o_c10,
  output logic [LEVEL_W-1:0] o_c5,
  output logic [3:0]         o_err,
  output logic               o_valid,
  output logic               o_scanDone
);

  localparam int CNT_W = 8;

  scanState_t         r_state;
  logic [3:0]         r_s;
  logic [3:0]         r_err;
  logic [3:0]         r_accepted;
  logic [LEVEL_W-1:0] r_c50;
  logic [LEVEL_W-1:0] r_c20;
  logic [LEVEL_W-1:0] r_c10;
  logic [LEVEL_W-1:0] r_c5;
  logic [LEVEL_W-1:0] r_last;
  logic               r_valid;
  logic               r_scanDone;
  logic               r_pass;
  logic [CNT_W-1:0]   r_dwell;
  logic [CNT_W-1:0]   r_match;
  logic [CNT_W-1:0]   r_tries;
  logic [3:0]         r_level;

  logic [3:0]         w_n;
  logic               w_ok;
  logic [CNT_W-1:0]   w_matchNext;
  logic [CNT_W-1:0]   w_triesNext;
  logic [3:0]         w_acceptedNext;

  therm_enc u_thermEnc (
    .i_f  (i_f),
    .o_n  (w_n),
    .o_ok (w_ok)
  );

  // Debounce bookkeeping for the sample seen this cycle: a repeat extends the run, a new
  // legal level starts a fresh run of one, an illegal code breaks the run
  always_comb begin
    w_matchNext = '0;
    if (w_ok) begin
      w_matchNext = (i_f == r_last) ? r_match + CNT_W'(1) : CNT_W'(1);
    end
    w_triesNext    = r_tries + CNT_W'(1);
    w_acceptedNext = r_accepted | r_s;
  end

  // Scan sequencer: select a tube, let the return path settle, debounce, then commit
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_s        <= SEL_IDLE;
      r_err      <= '0;
      r_accepted <= '0;
      r_c50      <= '0;
      r_c20      <= '0;
      r_c10      <= '0;
      r_c5       <= '0;
      r_last     <= '0;
      r_valid    <= 1'b0;
      r_scanDone <= 1'b0;
      r_pass     <= 1'b0;
      r_dwell    <= '0;
      r_match    <= '0;
      r_tries    <= '0;
      r_level    <= '0;
    end else begin
      r_scanDone <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_s <= SEL_IDLE;
          if (i_en) begin
            r_s     <= SEL_C50;
            r_state <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          r_match <= '0;
          r_tries <= '0;
          r_last  <= '0;
          if (r_dwell == CNT_W'(DWELL - 1)) begin
            r_dwell <= '0;
            r_state <= ST_SAMPLE;
          end else begin
            r_dwell <= r_dwell + CNT_W'(1);
          end
        end
        ST_SAMPLE: begin
          r_match <= w_matchNext;
          r_tries <= w_triesNext;
          r_last  <= i_f;
          r_level <= w_n;
          if (w_matchNext >= CNT_W'(STABLE)) begin
            r_pass  <= 1'b1;
            r_state <= ST_COMMIT;
          end else if (w_triesNext >= CNT_W'(MAX_TRIES)) begin
            r_pass  <= 1'b0;
            r_state <= ST_COMMIT;
          end
        end
        ST_COMMIT: begin
          if (r_pass) begin
            case (r_s)
              SEL_C50: r_c50 <= LEVEL_W'(r_level);
              SEL_C20: r_c20 <= LEVEL_W'(r_level);
              SEL_C10: r_c10 <= LEVEL_W'(r_level);
              SEL_C5:  r_c5  <= LEVEL_W'(r_level);
              default: ;
            endcase
            r_err      <= r_err & ~r_s;
            r_accepted <= w_acceptedNext;
            r_valid    <= r_valid | (&w_acceptedNext);
          end else begin
            r_err <= r_err | r_s;
          end
          if (r_s == SEL_C5) begin
            r_scanDone <= 1'b1;
          end
          if (i_en) begin
            r_s     <= nextSel(r_s);
            r_state <= ST_SETTLE;
          end else begin
            r_s     <= SEL_IDLE;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_s        = r_s;
  assign o_c50      = r_c50;
  assign o_c20      = r_c20;
  assign o_c10      = r_c10;
  assign o_c5       = r_c5;
  assign o_err      = r_err;
  assign o_valid    = r_valid;
  assign o_scanDone = r_scanDone;

endmodule

// File: tb/tb_tube_scan_enc.sv
// Bench for tube_scan_enc: a scripted tube return path, a per-tube reference model,
// a vector table of whole scans, corner-case sequences and random scans.
module tb_tube_scan_enc;
  import coin_pkg::*;

  localparam int DWELL     = 4;
  localparam int STABLE    = 2;
  localparam int MAX_TRIES = 8;

  logic       clock;
  logic       reset;
  logic       en;
  logic [8:0] f;
  logic [3:0] s;
  logic [8:0] c50;
  logic [8:0] c20;
  logic [8:0] c10;
  logic [8:0] c5;
  logic [3:0] err;
  logic       valid;
  logic       scanDone;

  int checks   = 0;
  int failures = 0;

  // Reference state: what the outputs must hold after the commits seen so far
  int expCount [4];
  bit expErr   [4];
  bit accepted [4];
  bit expValid;

  // Per-tube script of F values, one per sample cycle; the last value is held
  logic [8:0] tubeSeq [4][$];

  logic [3:0] drvPrevS;
  int         drvSince;

  typedef struct {
    logic [3:0][8:0] f;
    logic [3:0][3:0] n;
    logic [3:0]      e;
    bit              v;
  } scanVec_t;

  scanVec_t vecs [5];

  tube_scan_enc #(
    .DWELL     (DWELL),
    .STABLE    (STABLE),
    .MAX_TRIES (MAX_TRIES)
  ) dut (
    .i_clk      (clock),
    .i_rst      (reset),
    .i_en       (en),
    .i_f        (f),
    .o_s        (s),
    .o_c50      (c50),
    .o_c20      (c20),
    .o_c10      (c10),
    .o_c5       (c5),
    .o_err      (err),
    .o_valid    (valid),
    .o_scanDone (scanDone)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [3:0] tubeSel(input int t);
    return 4'b1000 >> t;
  endfunction

  function automatic int selToTube(input logic [3:0] sel);
    case (sel)
      4'b1000: return 0;
      4'b0100: return 1;
      4'b0010: return 2;
      4'b0001: return 3;
      default: return -1;
    endcase
  endfunction

  function automatic logic [8:0] seqAt(input int t, input int j);
    if (j < tubeSeq[t].size()) return tubeSeq[t][j];
    return tubeSeq[t][tubeSeq[t].size() - 1];
  endfunction

  function automatic int getCount(input int t);
    case (t)
      0:       return int'(c50);
      1:       return int'(c20);
      2:       return int'(c10);
      default: return int'(c5);
    endcase
  endfunction

  function automatic int errVec();
    return int'({expErr[0], expErr[1], expErr[2], expErr[3]});
  endfunction

  function automatic scanVec_t mkVec(input logic [8:0] f50, input logic [8:0] f20,
                                     input logic [8:0] f10, input logic [8:0] f5,
                                     input int n50, input int n20, input int n10,
                                     input int n5, input logic [3:0] e, input bit v);
    scanVec_t m;
    m.f[0] = f50; m.f[1] = f20; m.f[2] = f10; m.f[3] = f5;
    m.n[0] = 4'(n50); m.n[1] = 4'(n20); m.n[2] = 4'(n10); m.n[3] = 4'(n5);
    m.e = e;
    m.v = v;
    return m;
  endfunction

  // A tube's result from its script: legal means all set bits packed at the bottom
  // and at most eight of them; accept once STABLE equal legal readings run back to back
  function automatic void tubeOutcome(input int t, output bit pass, output int n,
                                      output int samples);
    int match;
    int lastN;
    int ones;
    logic [8:0] v;
    match = 0;
    lastN = -1;
    pass = 1'b0;
    n = 0;
    samples = 0;
    for (int j = 0; j < MAX_TRIES; j++) begin
      v = seqAt(t, j);
      ones = $countones(v);
      samples = j + 1;
      if (ones <= MAX_LEVEL && v == 9'((1 << ones) - 1)) begin
        match = (ones == lastN) ? match + 1 : 1;
        lastN = ones;
      end else begin
        match = 0;
        lastN = -1;
      end
      if (match >= STABLE) begin
        pass = 1'b1;
        n = ones;
        return;
      end
    end
  endfunction

  function automatic logic [8:0] randLevel(input logic [8:0] prev);
    int pick;
    pick = $urandom_range(0, 9);
    if (pick < 4) return prev;
    if (pick < 8) return 9'((1 << $urandom_range(0, 8)) - 1);
    return 9'($urandom);
  endfunction

  task automatic resetModel();
    for (int t = 0; t < 4; t++) begin
      expCount[t] = 0;
      expErr[t]   = 1'b0;
      accepted[t] = 1'b0;
    end
    expValid = 1'b0;
  endtask

  task automatic commitModel(input int t, input bit pass, input int n);
    if (pass) begin
      expCount[t] = n;
      expErr[t]   = 1'b0;
      accepted[t] = 1'b1;
      if (accepted[0] && accepted[1] && accepted[2] && accepted[3]) expValid = 1'b1;
    end else begin
      expErr[t] = 1'b1;
    end
  endtask

  task automatic setConst(input int t, input logic [8:0] v);
    tubeSeq[t].delete();
    tubeSeq[t].push_back(v);
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  task automatic checkState(input string tag);
    checkOutput({tag, " c50"}, int'(c50), expCount[0]);
    checkOutput({tag, " c20"}, int'(c20), expCount[1]);
    checkOutput({tag, " c10"}, int'(c10), expCount[2]);
    checkOutput({tag, " c5"}, int'(c5), expCount[3]);
    checkOutput({tag, " err"}, int'(err), errVec());
    checkOutput({tag, " valid"}, int'(valid), int'(expValid));
  endtask

  task automatic checkZero(input string tag);
    checkOutput({tag, " s"}, int'(s), 0);
    checkOutput({tag, " c50"}, int'(c50), 0);
    checkOutput({tag, " c20"}, int'(c20), 0);
    checkOutput({tag, " c10"}, int'(c10), 0);
    checkOutput({tag, " c5"}, int'(c5), 0);
    checkOutput({tag, " err"}, int'(err), 0);
    checkOutput({tag, " valid"}, int'(valid), 0);
    checkOutput({tag, " scan_done"}, int'(scanDone), 0);
  endtask

  // One scan from IDLE covering tubes 0..lastTube; en drops during the last tube's settle
  task automatic applyStimulus(input int lastTube, input string tag);
    bit pass;
    int n;
    int samples;
    int dur;
    en = 1'b1;
    @(posedge clock); #1;
    checkOutput({tag, " start sel"}, int'(s), int'(SEL_C50));
    for (int t = 0; t <= lastTube; t++) begin
      if (t == lastTube) en = 1'b0;
      tubeOutcome(t, pass, n, samples);
      dur = DWELL + samples + 1;
      repeat (dur - 1) @(posedge clock);
      #1;
      checkOutput($sformatf("%s t%0d pre-commit sel", tag, t), int'(s), int'(tubeSel(t)));
      checkOutput($sformatf("%s t%0d pre-commit done", tag, t), int'(scanDone), 0);
      @(posedge clock); #1;
      commitModel(t, pass, n);
      checkOutput($sformatf("%s t%0d next sel", tag, t), int'(s),
                  (t == lastTube) ? 0 : int'(tubeSel(t + 1)));
      checkOutput($sformatf("%s t%0d scan_done", tag, t), int'(scanDone), (t == 3) ? 1 : 0);
      checkState($sformatf("%s t%0d", tag, t));
    end
    @(posedge clock); #1;
    checkOutput({tag, " idle sel"}, int'(s), 0);
    checkOutput({tag, " idle done"}, int'(scanDone), 0);
  endtask

  // Tube return path: the selected tube's script once settling is over, junk otherwise
  initial begin
    drvPrevS = 4'b0000;
    drvSince = 0;
    f = 9'h000;
    forever begin
      @(posedge clock); #1;
      if (s != drvPrevS) begin
        drvPrevS = s;
        drvSince = 0;
      end else begin
        drvSince++;
      end
      if (selToTube(s) < 0 || drvSince < DWELL) f = 9'($urandom);
      else f = seqAt(selToTube(s), drvSince - DWELL);
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit pass;
    int n;
    int samples;
    int edges;
    logic [8:0] prev;

    vecs[0] = mkVec(9'h0FF, 9'h007, 9'h015, 9'h01F, 8, 3, 0, 5, 4'b0010, 1'b0);
    vecs[1] = mkVec(9'h0FF, 9'h007, 9'h001, 9'h01F, 8, 3, 1, 5, 4'b0000, 1'b1);
    vecs[2] = mkVec(9'h003, 9'h0FF, 9'h000, 9'h1FF, 2, 8, 0, 5, 4'b0001, 1'b1);
    vecs[3] = mkVec(9'h1FE, 9'h000, 9'h07F, 9'h00F, 2, 0, 7, 4, 4'b1000, 1'b1);
    vecs[4] = mkVec(9'h001, 9'h101, 9'h03F, 9'h1FF, 1, 0, 6, 4, 4'b0101, 1'b1);

    for (int t = 0; t < 4; t++) setConst(t, 9'h000);
    resetModel();
    reset = 1'b1;
    en = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    checkZero("in reset");
    reset = 1'b0;
    @(posedge clock); #1;
    checkZero("after reset");

    // Whole scans with a fixed level per tube, starting from reset state
    for (int k = 0; k < 5; k++) begin
      for (int t = 0; t < 4; t++) setConst(t, vecs[k].f[t]);
      applyStimulus(3, $sformatf("vec%0d", k));
      for (int t = 0; t < 4; t++) begin
        checkOutput($sformatf("vec%0d table count t%0d", k, t), getCount(t), int'(vecs[k].n[t]));
      end
      checkOutput($sformatf("vec%0d table err", k), int'(err), int'(vecs[k].e));
      checkOutput($sformatf("vec%0d table valid", k), int'(valid), int'(vecs[k].v));
    end

    // Bouncing C20 reading settles on level 4
    setConst(0, 9'h0FF);
    tubeSeq[1].delete();
    tubeSeq[1].push_back(9'h007);
    tubeSeq[1].push_back(9'h00F);
    tubeSeq[1].push_back(9'h007);
    tubeSeq[1].push_back(9'h00F);
    setConst(2, 9'h000);
    setConst(3, 9'h01F);
    applyStimulus(3, "bounce");
    checkOutput("bounce c20", int'(c20), 4);
    checkOutput("bounce err2", int'(err[2]), 0);

    // en dropped during C20 settle, then a fresh scan must start back at C50
    setConst(1, 9'h003);
    applyStimulus(1, "stop");
    checkOutput("stop c20", int'(c20), 2);
    applyStimulus(3, "restart");

    // Reset while the C50 tube is sampling
    en = 1'b1;
    @(posedge clock); #1;
    checkOutput("midrst start sel", int'(s), int'(SEL_C50));
    repeat (DWELL + 1) @(posedge clock);
    #1;
    reset = 1'b1;
    en = 1'b0;
    @(posedge clock); #1;
    checkZero("midrst");
    reset = 1'b0;
    resetModel();
    @(posedge clock); #1;
    checkOutput("midrst idle sel", int'(s), 0);

    // Clean scan from reset: levels 8/3/0/5, scan_done 28 edges after en is taken
    setConst(0, 9'h0FF);
    setConst(1, 9'h007);
    setConst(2, 9'h000);
    setConst(3, 9'h01F);
    en = 1'b1;
    @(posedge clock); #1;
    checkOutput("clean start sel", int'(s), int'(SEL_C50));
    edges = 0;
    while (scanDone !== 1'b1 && edges < 100) begin
      @(posedge clock); #1;
      edges++;
      if (edges == 22) en = 1'b0;
    end
    checkOutput("clean scan_done edge", edges, 28);
    checkOutput("clean c50", int'(c50), 8);
    checkOutput("clean c20", int'(c20), 3);
    checkOutput("clean c10", int'(c10), 0);
    checkOutput("clean c5", int'(c5), 5);
    checkOutput("clean err", int'(err), 0);
    checkOutput("clean valid", int'(valid), 1);
    for (int t = 0; t < 4; t++) begin
      tubeOutcome(t, pass, n, samples);
      commitModel(t, pass, n);
    end
    en = 1'b0;
    @(posedge clock); #1;
    checkOutput("clean idle sel", int'(s), 0);

    // Random scripts per tube, random stopping points
    for (int r = 0; r < 12; r++) begin
      for (int t = 0; t < 4; t++) begin
        tubeSeq[t].delete();
        prev = 9'((1 << $urandom_range(0, 8)) - 1);
        for (int j = 0; j < $urandom_range(1, 10); j++) begin
          prev = randLevel(prev);
          tubeSeq[t].push_back(prev);
        end
      end
      applyStimulus(($urandom_range(0, 1) == 1) ? 3 : int'($urandom_range(0, 3)),
                    $sformatf("rand%0d", r));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tube_scan_enc.md
# tube_scan_enc

Scanning reader for the coin-tube level display bus. It drives the one-hot tube selector `S`, samples the shared 9-bit thermometer bus `F` returned by the display decoder or the tube level sensors, and validates and debounces each reading. Each reading is converted back into a per-denomination count (0..8) on `C50`, `C20`, `C10` and `C5`, the same 9-bit count format that the display decoder consumes. The block sits between the tube sensor/display multiplexer and the change-making logic.

## Interface
- `DWELL`, default 4: settle cycles after `S` changes, before the first sample.
- `STABLE`, default 2: consecutive identical valid samples required to accept a reading.
- `MAX_TRIES`, default 8: sample cycles allowed per tube before declaring an error.
- `clk` input, 1 bit: the single clock.
- `rst` input, 1 bit: reset, synchronous, active-high.
- `en` input, 1 bit: scan enable.
- `F` input, 9 bits: thermometer level of the currently selected tube.
- `S` output, 4 bits: one-hot tube select. `1000` selects C50, `0100` C20, `0010` C10, `0001` C5. `0000` means idle.
- `C50`, `C20`, `C10`, `C5` outputs, 9 bits each: last accepted count, range 0..8, zero-extended.
- `err` output, 4 bits: per-tube flag meaning the last attempt failed. Bit order is [3]=C50 through [0]=C5.
- `valid` output, 1 bit: every tube has been accepted at least once since reset.
- `scan_done` output, 1 bit: one-cycle pulse when the C5 tube commits.

## Operation
- **Reset values.** While `rst` is high, and on the cycle after it, all outputs are 0: `S=0000`, all counts 0, `err=0000`, `valid=0`, `scan_done=0`. The FSM is in IDLE.
- **FSM states:** IDLE, SETTLE, SAMPLE, COMMIT.
- **IDLE.**
  - Drives `S=0000`.
  - When `en=1`, loads `S=1000` and goes to SETTLE.
- **SETTLE.**
  - Holds `S` for exactly `DWELL` cycles, then goes to SAMPLE.
  - Clears the match counter, try counter and last-sample register on entry.
- **SAMPLE, one sample per cycle.**
  - Encode `F`. The sample is valid only if `F` is one of the 9 legal codes `(1<<n)-1` for n=0..8. The code `111111111` and all non-contiguous patterns are invalid.
  - If the sample is valid and equals the last sample, increment the match counter. If it is valid but different, set match=1. If it is invalid, set match=0.
  - The try counter increments every SAMPLE cycle.
  - Go to COMMIT with success when match reaches `STABLE`. Go to COMMIT with failure when tries reach `MAX_TRIES` first. Success takes priority if both occur on the same cycle.
- **COMMIT, one cycle.**
  - On success, write n into the selected count register and clear that tube's `err` bit.
  - On failure, keep the old count and set that tube's `err` bit.
  - Set the tube's internal accepted flag on success. `valid` is the AND of the four accepted flags and, once set, stays high until `rst`.
  - If `S=0001`, pulse `scan_done`.
  - If `en=1`, rotate `S` (`1000`→`0100`→`0010`→`0001`→`1000`, wrapping) and go to SETTLE. If `en=0`, go to IDLE with `S=0000`.
- **`en` deasserted mid-tube.** The current tube runs to completion through COMMIT; only then does the FSM stop. A later re-enable restarts at `1000`.
- **Count updates.** Only the selected tube's count register can change, and only in COMMIT.
- **`rst` mid-operation.** `rst` overrides everything. It returns the block to the reset values on the next edge and discards any partial sample state.

## Timing
- `S` is registered and changes only on the edge that enters SETTLE or IDLE.
- `F` is a combinational return path and is sampled on the first edge after SETTLE completes.
- **Minimum time per tube:** `DWELL` + `STABLE` + 1 cycles, which is 7 with the defaults. A full scan takes 28 cycles minimum.
- **Maximum time per tube:** `DWELL` + `MAX_TRIES` + 1 cycles, which is 13 with the defaults.
- Count, `err` and `valid` updates become visible the cycle after COMMIT, together with the new `S`.
- From `en` rising in IDLE, the first `scan_done` occurs 28 cycles later when `F` is stable.

## Structure
- **Shared package (`coin_pkg`):**
  - tube-select one-hot constants `SEL_C50`, `SEL_C20`, `SEL_C10`, `SEL_C5`;
  - `LEVEL_W = 9`;
  - `MAX_LEVEL = 8`;
  - the FSM state type.
- **Sub-module `therm_enc`:** combinational. It maps the 9-bit `F` to a 4-bit count n plus an `ok` flag, and is reused by the display self-test.

## Test plan
- **Clean scan:** reset, then `en=1`. The bench models `F` from `S` with levels 8/3/0/5 for C50/C20/C10/C5. Required: `scan_done` at cycle 28; C50=8, C20=3, C10=0, C5=5; `valid=1`; `err=0000`.
- **Bounce:** for the C20 tube, `F` alternates `000000111`/`000001111` for 3 samples, then holds `000001111`. Required: C20=4 after 3+2 sample cycles, and `err[2]=0`.
- **Illegal code:** hold the C10 tube at `000010101`. Required: after 8 tries `err[1]=1`, C10 keeps its old value, and `valid` does not become 1 on this scan. Fixing `F` to `000000001` clears `err[1]` on the next scan and sets C10=1.
- **All-ones:** hold C5 at `111111111`. Required: rejected, `err[0]=1`.
- **Stop mid-tube:** drop `en` during SETTLE of `0100`. Required: that tube commits, then `S=0000` in IDLE; re-enabling restarts at `1000`.
- **Reset mid-SAMPLE:** assert `rst` for 1 cycle. Required: all outputs 0 on the next cycle, and the FSM is in IDLE.
